reg_file_memory: RTL

REG_FILE_MEMORY -- requirements
Module: reg_file_memory

---
 rtl/reg_file_memory.sv | 113 +++++++++++
 1 files changed

// File: rtl/reg_file_memory.sv
// ---------------------------------------------------------------------------
// reg_file_memory
//
// Purpose:
//   Small register-file memory with one write port and one registered read
//   port. Storage is DEPTH x WIDTH flops. A per-word "written" flag records
//   which words have been stored since the last reset. Reads take one cycle.
//   Each read produces a one-cycle mem_valid pulse.
//
// Configuration:
//   WRITE_BYPASS_EN - when defined, a store and a load to the same address in
//                     the same cycle return the new data (write-first).
//                     When undefined (default), they return the old word
//                     (read-first). The write completes in both builds.
//
// Ports:
//   clk        in   1      sole clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   data       in   WIDTH  write data
//   wr_addr    in   AW     write address
//   store      in   1      write enable
//   rd_addr    in   AW     read address
//   load       in   1      read request
//   memory     out  WIDTH  registered read data, holds last read value
//   mem_valid  out  1      pulses the cycle after any load
//   written    out  DEPTH  bit i set once word i has been written
// ---------------------------------------------------------------------------
module reg_file_memory #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    wr_addr,
    input  logic             store,
    input  logic [AW-1:0]    rd_addr,
    input  logic             load,
    output logic [WIDTH-1:0] memory,
    output logic             mem_valid,
    output logic [DEPTH-1:0] written
);

    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] word_d [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic [WIDTH-1:0] memory_q, memory_d;
    logic             mem_valid_q, mem_valid_d;
    logic [WIDTH-1:0] rd_word;

    // Read mux: the address is matched against each legal index. An
    // out-of-range address matches nothing, so it reads as all-zeros
    // without a separate range check.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
`ifdef WRITE_BYPASS_EN
                rd_word = (store && (wr_addr == AW'(i))) ? data : word_q[i];
`else
                rd_word = word_q[i];
`endif
            end
        end
    end

    // Write decode works the same way. An out-of-range write address
    // matches no word, so the store is dropped and no written bit changes.
    always_comb begin
        word_d    = word_q;
        written_d = written_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (store && (wr_addr == AW'(i))) begin
                word_d[i]    = data;
                written_d[i] = 1'b1;
            end
        end
    end

    // The read register only updates on a load, so it holds its value
    // across store-only cycles.
    always_comb begin
        memory_d    = memory_q;
        mem_valid_d = load;
        if (load) begin
            memory_d = rd_word;
        end
    end

    // Reset takes priority over store and load. Clearing mem_valid here
    // also discards a load that is still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
            end
            written_q   <= '0;
            memory_q    <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            word_q      <= word_d;
            written_q   <= written_d;
            memory_q    <= memory_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign memory    = memory_q;
    assign mem_valid = mem_valid_q;
    assign written   = written_q;

endmodule
